// File: rtl/ring_pkg.sv
// Shared definitions for logic that consumes the one-hot ring counter.
//   RING_W    : width of the one-hot ring vector
//   IDX_W     : width of the encoded phase index
//   next_idx  : expected successor of an index for a given rotation direction
//   is_onehot : true when exactly one bit of the ring vector is set
package ring_pkg;

    localparam int unsigned RING_W = 8;
    localparam int unsigned IDX_W  = 3;

    // dir = 1 counts down (7,6,...,0,7), dir = 0 counts up; wraps modulo 2^IDX_W
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic             dir);
        logic [IDX_W-1:0] nxt;
        if (dir) begin
            nxt = idx - IDX_W'(1);
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    // Clearing the lowest set bit leaves zero only for a single-bit vector
    function automatic logic is_onehot(input logic [RING_W-1:0] vec);
        logic [RING_W-1:0] low_cleared;
        low_cleared = vec & (vec - RING_W'(1));
        return (vec != '0) && (low_cleared == '0);
    endfunction

endpackage

// File: rtl/ring_onehot_encoder.sv
// Combinational one-hot to binary encoder for the ring vector.
// Ports:
//   vec     : ring vector to encode
//   idx_c   : position of the set bit (meaningless unless legal_c is 1)
//   legal_c : vec has exactly one bit set
module ring_onehot_encoder
    import ring_pkg::*;
(
    input  logic [RING_W-1:0] vec,
    output logic [IDX_W-1:0]  idx_c,
    output logic              legal_c
);

    // OR of the positions of all set bits; exact for a legal one-hot input
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < int'(RING_W); i++) begin
            if (vec[i]) begin
                idx_c = idx_c | IDX_W'(i);
            end
        end
    end

    assign legal_c = is_onehot(vec);

endmodule

// File: rtl/ring_phase_monitor.sv
// Registers the one-hot ring vector, encodes its phase, counts completed
// revolutions and flags one-hot or rotation-sequence violations.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : sample enable; state holds while low
//   ring_in     : one-hot ring vector from the ring counter
//   clr_err     : synchronous clear of err_sticky / err_count (an error in
//                 the same cycle wins)
//   phase_idx   : index of the set bit of the last legal sample
//   phase_valid : last sample was one-hot
//   rev_pulse   : one-cycle pulse on a completed revolution
//   rev_count   : revolution counter, wraps silently
//   err_onehot  : one-cycle pulse, last sample not one-hot
//   err_seq     : one-cycle pulse, one-hot but not the expected next index
//   err_sticky  : latched OR of the error pulses
//   err_count   : saturating error event counter
module ring_phase_monitor
    import ring_pkg::*;
#(
    parameter int unsigned REV_W    = 8,
    parameter int unsigned ERR_W    = 4,
    parameter bit          DIR_DOWN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [RING_W-1:0] ring_in,
    input  logic              clr_err,
    output logic [IDX_W-1:0]  phase_idx,
    output logic              phase_valid,
    output logic              rev_pulse,
    output logic [REV_W-1:0]  rev_count,
    output logic              err_onehot,
    output logic              err_seq,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count
);

    // Index the ring leaves when it completes a revolution
    localparam logic [IDX_W-1:0] WRAP_FROM = DIR_DOWN ? IDX_W'(0) : IDX_W'(RING_W - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    logic [IDX_W-1:0] enc_idx_c;
    logic             enc_legal_c;
    logic [IDX_W-1:0] exp_idx_c;

    logic             synced;
    logic [IDX_W-1:0] prev_idx;

    logic [IDX_W-1:0] phase_idx_d;
    logic             phase_valid_d;
    logic             rev_pulse_d;
    logic [REV_W-1:0] rev_count_d;
    logic             err_onehot_d;
    logic             err_seq_d;
    logic             err_sticky_d;
    logic [ERR_W-1:0] err_count_d;
    logic             synced_d;
    logic [IDX_W-1:0] prev_idx_d;

    ring_onehot_encoder u_enc (
        .vec     (ring_in),
        .idx_c   (enc_idx_c),
        .legal_c (enc_legal_c)
    );

    assign exp_idx_c = next_idx(prev_idx, DIR_DOWN);

    // Next-state: sampling, sequence check, revolution and error accounting
    always_comb begin
        phase_idx_d   = phase_idx;
        phase_valid_d = phase_valid;
        rev_pulse_d   = 1'b0;
        rev_count_d   = rev_count;
        err_onehot_d  = 1'b0;
        err_seq_d     = 1'b0;
        err_sticky_d  = err_sticky;
        err_count_d   = err_count;
        synced_d      = synced;
        prev_idx_d    = prev_idx;

        if (!ena) begin
            // Gap in sampling: the ring may have moved, so do not trust prev_idx
            synced_d = 1'b0;
        end else if (!enc_legal_c) begin
            err_onehot_d  = 1'b1;
            phase_valid_d = 1'b0;
            synced_d      = 1'b0;
        end else begin
            phase_valid_d = 1'b1;
            phase_idx_d   = enc_idx_c;
            prev_idx_d    = enc_idx_c;
            synced_d      = 1'b1;
            if (synced) begin
                if (enc_idx_c != exp_idx_c) begin
                    // Skip or stall: flag it and resync on the new index
                    err_seq_d = 1'b1;
                end else if (prev_idx == WRAP_FROM) begin
                    rev_pulse_d = 1'b1;
                    rev_count_d = rev_count + REV_W'(1);
                end
            end
        end

        // Error bookkeeping; a new error outranks a simultaneous clear
        if (ena) begin
            if (err_onehot_d || err_seq_d) begin
                err_sticky_d = 1'b1;
                if (clr_err) begin
                    err_count_d = ERR_W'(1);
                end else if (err_count != ERR_MAX) begin
                    err_count_d = err_count + ERR_W'(1);
                end
            end else if (clr_err) begin
                err_sticky_d = 1'b0;
                err_count_d  = '0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_idx   <= '0;
            phase_valid <= 1'b0;
            rev_pulse   <= 1'b0;
            rev_count   <= '0;
            err_onehot  <= 1'b0;
            err_seq     <= 1'b0;
            err_sticky  <= 1'b0;
            err_count   <= '0;
            synced      <= 1'b0;
            prev_idx    <= '0;
        end else begin
            phase_idx   <= phase_idx_d;
            phase_valid <= phase_valid_d;
            rev_pulse   <= rev_pulse_d;
            rev_count   <= rev_count_d;
            err_onehot  <= err_onehot_d;
            err_seq     <= err_seq_d;
            err_sticky  <= err_sticky_d;
            err_count   <= err_count_d;
            synced      <= synced_d;
            prev_idx    <= prev_idx_d;
        end
    end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor (REV_W=8, ERR_W=4, DIR_DOWN=1).
// A behavioural reference model predicts every output for each driven
// sample; predictions are queued and compared after the sampling edge.
module tb_ring_phase_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ring_in = 8'h00;
    logic       clr_err = 1'b0;

    logic [2:0] phase_idx;
    logic       phase_valid;
    logic       rev_pulse;
    logic [7:0] rev_count;
    logic       err_onehot;
    logic       err_seq;
    logic       err_sticky;
    logic [3:0] err_count;

    ring_phase_monitor #(
        .REV_W    (8),
        .ERR_W    (4),
        .DIR_DOWN (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .ring_in     (ring_in),
        .clr_err     (clr_err),
        .phase_idx   (phase_idx),
        .phase_valid (phase_valid),
        .rev_pulse   (rev_pulse),
        .rev_count   (rev_count),
        .err_onehot  (err_onehot),
        .err_seq     (err_seq),
        .err_sticky  (err_sticky),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic       valid;
        logic       rev;
        logic [7:0] rc;
        logic       eo;
        logic       es;
        logic       st;
        logic [3:0] ec;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit m_synced;
    int m_prev;
    int m_idx;
    bit m_valid;
    int m_rc;
    bit m_st;
    int m_cnt;
    int cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_synced = 1'b0;
        m_prev   = 0;
        m_idx    = 0;
        m_valid  = 1'b0;
        m_rc     = 0;
        m_st     = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic model(input logic e, input logic [7:0] r, input logic c, output exp_t x);
        bit eo, es, rv;
        int k;
        eo = 1'b0; es = 1'b0; rv = 1'b0; k = 0;
        if (!e) begin
            m_synced = 1'b0;
        end else if ($countones(r) != 1) begin
            eo = 1'b1;
            m_valid = 1'b0;
            m_synced = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) if (r[i]) k = i;
            m_valid = 1'b1;
            if (m_synced) begin
                if (k != (m_prev + 7) % 8) es = 1'b1;
                else if (m_prev == 0 && k == 7) begin
                    rv = 1'b1;
                    m_rc = (m_rc + 1) % 256;
                end
            end
            m_synced = 1'b1;
            m_prev = k;
            m_idx = k;
        end
        if (e) begin
            if (eo || es) begin
                m_st = 1'b1;
                m_cnt = c ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
            end else if (c) begin
                m_st = 1'b0;
                m_cnt = 0;
            end
        end
        x.idx = 3'(m_idx); x.valid = m_valid; x.rev = rv; x.rc = 8'(m_rc);
        x.eo = eo; x.es = es; x.st = m_st; x.ec = 4'(m_cnt);
    endtask

    task automatic compare_out();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            x = sb.pop_front();
            chk("phase_idx",   32'(phase_idx),   32'(x.idx));
            chk("phase_valid", 32'(phase_valid), 32'(x.valid));
            chk("rev_pulse",   32'(rev_pulse),   32'(x.rev));
            chk("rev_count",   32'(rev_count),   32'(x.rc));
            chk("err_onehot",  32'(err_onehot),  32'(x.eo));
            chk("err_seq",     32'(err_seq),     32'(x.es));
            chk("err_sticky",  32'(err_sticky),  32'(x.st));
            chk("err_count",   32'(err_count),   32'(x.ec));
        end
    endtask

    // Drive one sample, predict, then compare after the capturing edge
    task automatic step(input logic e, input logic [7:0] r, input logic c);
        exp_t x;
        ena = e; ring_in = r; clr_err = c;
        model(e, r, c, x);
        sb.push_back(x);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    function automatic logic [7:0] ring_of(input int k);
        logic [7:0] one;
        one = 8'h01;
        return one << k;
    endfunction

    // Advance the ring one position downwards and sample it
    task automatic adv(input logic e);
        cur = (cur + 7) % 8;
        step(e, ring_of(cur), 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_idx"}, 32'(phase_idx), 32'd0);
        chk({tag, "_flags"}, 32'({phase_valid, rev_pulse, err_onehot, err_seq, err_sticky}), 32'd0);
        chk({tag, "_rc"}, 32'(rev_count), 32'd0);
        chk({tag, "_ec"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        m_reset();
        ena = 1'b1; ring_in = 8'h80;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean rotation from the ring reset phase: 80,40,...,01,80 twice
        cur = 7;
        step(1'b1, 8'h80, 1'b0);
        chk("first_idx", 32'(phase_idx), 32'd7);
        for (int i = 0; i < 8; i++) adv(1'b1);
        chk("rev1_pulse", 32'(rev_pulse), 32'd1);
        chk("rev1_count", 32'(rev_count), 32'd1);
        for (int i = 0; i < 8; i++) adv(1'b1);
        chk("rev2_count", 32'(rev_count), 32'd2);
        chk("clean_sticky", 32'(err_sticky), 32'd0);

        // Empty vector mid-rotation, then resync without a sequence error
        adv(1'b1);
        adv(1'b1);
        step(1'b1, 8'h00, 1'b0);
        chk("zero_onehot", 32'(err_onehot), 32'd1);
        chk("zero_valid", 32'(phase_valid), 32'd0);
        chk("zero_hold_idx", 32'(phase_idx), 32'd5);
        chk("zero_count", 32'(err_count), 32'd1);
        adv(1'b1);
        chk("resync_seq", 32'(err_seq), 32'd0);

        // Run to index 5 (20) then skip to 04
        while (cur != 5) adv(1'b1);
        cur = 2;
        step(1'b1, 8'h04, 1'b0);
        chk("skip_seq", 32'(err_seq), 32'd1);
        chk("skip_rev", 32'(rev_pulse), 32'd0);
        chk("skip_count", 32'(err_count), 32'd2);
        adv(1'b1);
        adv(1'b1);
        adv(1'b1);
        chk("skip_then_rev", 32'(rev_pulse), 32'd1);

        // Two bits set, then clear colliding with a second illegal sample
        step(1'b1, 8'h18, 1'b0);
        step(1'b1, 8'h18, 1'b1);
        chk("clr_collide_sticky", 32'(err_sticky), 32'd1);
        chk("clr_collide_count", 32'(err_count), 32'd1);
        cur = 7;
        step(1'b1, 8'h80, 1'b1);
        chk("clr_sticky", 32'(err_sticky), 32'd0);
        chk("clr_count", 32'(err_count), 32'd0);

        // Enable gap of three cycles while the ring keeps moving
        adv(1'b1);
        adv(1'b1);
        for (int i = 0; i < 3; i++) adv(1'b0);
        chk("gap_hold_idx", 32'(phase_idx), 32'd5);
        chk("gap_no_pulse", 32'(rev_pulse), 32'd0);
        adv(1'b1);
        chk("gap_resume_seq", 32'(err_seq), 32'd0);
        adv(1'b1);
        adv(1'b1);
        chk("gap_rev", 32'(rev_pulse), 32'd1);
        chk("gap_rev_count", 32'(rev_count), 32'd5);

        // Asynchronous reset mid-operation
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cur = 7;
        step(1'b1, 8'h80, 1'b0);
        chk("post_reset_seq", 32'(err_seq), 32'd0);

        // 256 revolutions: count reaches 255 then wraps to 0 with a pulse
        for (int r = 0; r < 256; r++) begin
            for (int k = 0; k < 8; k++) adv(1'b1);
            if (r == 254) chk("rev_255", 32'(rev_count), 32'd255);
        end
        chk("rev_wrap_count", 32'(rev_count), 32'd0);
        chk("rev_wrap_pulse", 32'(rev_pulse), 32'd1);

        // Error counter saturation
        for (int i = 0; i < 20; i++) step(1'b1, (i % 2 == 0) ? 8'h00 : 8'h81, 1'b0);
        chk("sat_count", 32'(err_count), 32'd15);
        chk("sat_sticky", 32'(err_sticky), 32'd1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
- Downstream consumer of the 8-bit one-hot ring counter output.
- Registers the ring vector, encodes it to a 3-bit phase index and counts complete revolutions.
- Checks every sample for one-hot legality and correct rotation sequence, and flags violations.
- Provides phase and health status to the top-level I/O mux and to debug logic.

Parameters:
- REV_W, 8, width of the revolution counter.
- ERR_W, 4, width of the saturating error counter.
- DIR_DOWN, 1, rotation direction. 1 = expected index sequence 7,6,…,0,7. 0 = 0,1,…,7,0.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  sample enable; when low, all state holds
- ring_in  input  8  one-hot ring vector from the ring counter
- clr_err  input  1  synchronous clear of err_sticky and err_count
- phase_idx  output  3  encoded index of the set bit
- phase_valid  output  1  last sample was one-hot
- rev_pulse  output  1  one-cycle pulse on completed revolution
- rev_count  output  REV_W  revolution count, wraps modulo 2^REV_W
- err_onehot  output  1  one-cycle pulse: last sample not one-hot
- err_seq  output  1  one-cycle pulse: one-hot, but not the expected next index
- err_sticky  output  1  latched OR of both error pulses
- err_count  output  ERR_W  saturating count of error events

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset values: all outputs 0. Internal `synced` = 0, `prev_idx` = 0.
- Latency: all outputs are registered. Sample at edge N (ena=1) is reflected on outputs after edge N.
- ena=0:
  - No sampling; phase_idx, phase_valid, rev_count, err_sticky and err_count hold.
  - rev_pulse, err_onehot and err_seq are 0.
  - `synced` clears, so the first sample after ena returns is not sequence-checked.
- One-hot check (ena=1):
  - Zero bits set, or more than one bit set: err_onehot=1, phase_valid=0, phase_idx holds, `synced` clears.
  - No revolution is counted.
- Valid one-hot sample:
  - phase_valid=1, phase_idx = position of the set bit, `prev_idx` updates.
  - If `synced`=0: accept silently and set `synced`=1.
  - If `synced`=1: expected = prev_idx-1 mod 8 (DIR_DOWN=1) or prev_idx+1 mod 8 (DIR_DOWN=0).
    - Mismatch, including a repeated index (stall): err_seq=1 and resync to the new index. No revolution is counted.
- Revolution:
  - Condition: `synced`=1, the sequence is correct, and the transition is the wrap edge. Wrap edge is 0→7 (DIR_DOWN=1) or 7→0 (DIR_DOWN=0).
  - Action: rev_pulse=1 for one cycle and rev_count increments.
  - Wrap-around: rev_count wraps from 2^REV_W-1 to 0 with no flag.
- Error accounting:
  - Any error pulse sets err_sticky and increments err_count.
  - err_count saturates at 2^ERR_W-1.
  - clr_err=1: err_sticky←0 and err_count←0, unless an error event occurs in the same cycle. In that case err_sticky←1 and err_count←1 (set wins).
- Mutual exclusion: err_onehot and err_seq are never both 1 in the same cycle.
- Reset mid-operation: returns to reset values immediately and asynchronously. The next sample after release is unchecked.
- Ring reset phase: after a ring reset (index 7 for DIR_DOWN=1), index 7 is accepted as the first sample.

Decomposition:
- Shared package ring_pkg:
  - RING_W=8 and IDX_W=3.
  - Function next_idx(idx, dir).
  - Function is_onehot(vec).
- One sub-module: ring_onehot_encoder.
  - Combinational, 8→3 encode plus a `legal` flag.
  - Reused later by the ring-driven output sequencer.
- Everything else is inline in ring_phase_monitor.

Test Plan:
- Reset release with ring_in=8'h80, ena=1, 9 clean rotations (80,40,…,01,80):
  - phase_idx follows 7,6,…,0.
  - First rev_pulse on the 01→80 transition, rev_count=1; 8 cycles later rev_count=2.
  - All error outputs stay 0.
- ring_in=8'h00 for one cycle mid-rotation:
  - err_onehot=1 for one cycle, phase_valid=0, err_count=1, err_sticky=1.
  - The next valid sample produces no err_seq (resync).
- Skip 8'h20→8'h04:
  - err_seq=1, err_count increments, no rev_pulse.
  - Continuing 02,01,80 gives a valid rev_pulse.
- ring_in=8'h18 (two bits set), then clr_err asserted in the same cycle as a second illegal sample:
  - err_sticky stays 1 and err_count=1.
  - clr_err alone next cycle → both 0.
- Drop ena for 3 cycles mid-rotation while the ring advances:
  - Outputs hold during the gap.
  - No err_seq on re-enable, and rotation resumes counting.
- Force 255 revolutions with REV_W=8, then one more:
  - rev_count wraps to 0 with rev_pulse=1.
- Separately, 20 illegal samples:
  - err_count saturates at 15.
